// File: rtl/regfile_dump_reader.sv
// Debug reader on the spare register-file read port: fetches one register or
// all NUM_REGS registers and streams them out over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Abort beats every transition, and in IDLE it also swallows a same-cycle start.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    if (abort) begin
      state_d = IDLE;
      if (state_q != IDLE) begin
        last_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            mode_d  = mode;
            count_d = mode ? '0 : sel_addr;
            state_d = FETCH;
          end
        end
        FETCH: begin
          data_d  = rdata;
          addr_d  = count_q;
          last_d  = !mode_q || (count_q == LastAddr);
          state_d = SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (last_q) begin
              state_d = FIN;
            end else begin
              count_d = count_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign ra        = count_q;
  assign out_valid = (state_q == SEND);
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule
